mprj_io_cfg_loader: RTL and testbench

Sequencer that programs the user-project pad configuration chain. On a start pulse it fetches one configuration word per `mprj_io` pad from a word source through a req/ack handshake. It shifts each word out on a serial clock/data pair into the daisy-chained per-pad control blocks. It then issues a load strobe so every pad's mode (dm, inp_dis, oeb, vtrip, slow, holdover, analog_*) updates at once. It sits in housekeeping, between the configuration register file and the pad control chain feeding `chip_io`.

---
 rtl/mprj_cfg_pkg.sv | 33 +++
 rtl/mprj_cfg_shifter.sv | 74 +++++++
 rtl/mprj_io_cfg_loader.sv | 110 +++++++++++
 tb/tb_mprj_io_cfg_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_cfg_pkg.sv
// mprj_cfg_pkg
//   Shared definitions for the user-project pad configuration loader:
//   FSM state encoding, default chain geometry and counter-width helpers.
package mprj_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
      ST_LOAD,
      ST_FIN
   } cfg_state_e;

   localparam int DEF_NUM_PADS = 38;
   localparam int DEF_CFG_BITS = 13;
   localparam int DEF_CLK_DIV  = 2;

   // Pad index width; a one-pad chain still needs a one-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bit counter width: counts 0..CFG_BITS-1.
   function automatic int bcnt_w(input int b);
      return (b > 1) ? $clog2(b) : 1;
   endfunction

   // Phase counter width: holds 0..CLK_DIV.
   function automatic int pcnt_w(input int d);
      return (d > 0) ? $clog2(d + 1) : 1;
   endfunction

endpackage

// File: rtl/mprj_cfg_shifter.sv
// mprj_cfg_shifter
//   Serialises one configuration word MSB first onto serial_clock /
//   serial_data. Each bit is a low phase then a high phase, CLK_DIV
//   cycles each.
// Ports:
//   clock, resetn   core clock, async active-low reset
//   load, load_data capture a new word and restart at its MSB
//   go              advance the phase/bit counters (held high while shifting)
//   word_done       high on the last cycle of the last high phase
//   serial_clock    chain shift clock
//   serial_data     chain shift data
module mprj_cfg_shifter
   import mprj_cfg_pkg::*;
#(
   parameter int CFG_BITS = DEF_CFG_BITS,
   parameter int CLK_DIV  = DEF_CLK_DIV
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                load,
   input  logic [CFG_BITS-1:0] load_data,
   input  logic                go,
   output logic                word_done,
   output logic                serial_clock,
   output logic                serial_data
);

   localparam int BW = bcnt_w(CFG_BITS);
   localparam int PW = pcnt_w(CLK_DIV);
   localparam logic [BW-1:0] BIT_TC = BW'(CFG_BITS - 1);
   localparam logic [PW-1:0] PH_TC  = PW'(CLK_DIV - 1);

   logic [CFG_BITS-1:0] sreg;
   logic [BW-1:0]       bcnt;
   logic [PW-1:0]       pcnt;
   logic                hi;
   logic                ph_end;

   assign ph_end       = (pcnt == PH_TC);
   assign word_done    = go && hi && ph_end && (bcnt == BIT_TC);
   // Data comes straight off the register MSB, so it only moves when the
   // register shifts, which happens at the end of a high phase, i.e. on
   // the first cycle of the following low phase.
   assign serial_clock = hi;
   assign serial_data  = sreg[CFG_BITS-1];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sreg <= '0;
         bcnt <= '0;
         pcnt <= '0;
         hi   <= 1'b0;
      end else if (load) begin
         sreg <= load_data;
         bcnt <= '0;
         pcnt <= '0;
         hi   <= 1'b0;
      end else if (go) begin
         if (ph_end) begin
            pcnt <= '0;
            hi   <= !hi;
            if (hi) begin
               sreg <= sreg << 1;
               // Bit counter parks at terminal count after the last bit.
               if (bcnt != BIT_TC)
                  bcnt <= bcnt + BW'(1);
            end
         end else begin
            pcnt <= pcnt + PW'(1);
         end
      end
   end

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader
//   Programs the mprj_io pad control daisy chain. On xfer_start it fetches
//   one word per pad (highest index first) over a req/ack handshake, shifts
//   each word out serially, then pulses serial_load so all pads update
//   together.
// Ports:
//   clock, resetn               core clock, async active-low reset
//   xfer_start                  one-cycle transfer request (IDLE only)
//   busy, done                  transfer in progress / completion pulse
//   cfg_req, cfg_idx            word request and pad index to the source
//   cfg_ack, cfg_data           source handshake and word (same cycle)
//   serial_clock, serial_data   chain shift clock / data
//   serial_load                 chain load strobe
module mprj_io_cfg_loader
   import mprj_cfg_pkg::*;
#(
   parameter int NUM_PADS = DEF_NUM_PADS,
   parameter int CFG_BITS = DEF_CFG_BITS,
   parameter int CLK_DIV  = DEF_CLK_DIV
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       xfer_start,
   output logic                       busy,
   output logic                       done,
   output logic                       cfg_req,
   output logic [idx_w(NUM_PADS)-1:0] cfg_idx,
   input  logic                       cfg_ack,
   input  logic [CFG_BITS-1:0]        cfg_data,
   output logic                       serial_clock,
   output logic                       serial_data,
   output logic                       serial_load
);

   localparam int IW = idx_w(NUM_PADS);
   localparam int PW = pcnt_w(CLK_DIV);
   localparam logic [IW-1:0] IDX_TOP = IW'(NUM_PADS - 1);
   localparam logic [PW-1:0] LD_TC   = PW'(CLK_DIV - 1);

   cfg_state_e    state, state_nxt;
   logic [PW-1:0] lcnt;
   logic          word_done;
   logic          capture;
   logic          shift_go;

   // An ack only counts while the request is up.
   assign capture  = (state == ST_FETCH) && cfg_ack;
   assign shift_go = (state == ST_SHIFT);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (xfer_start) state_nxt = ST_FETCH;
         ST_FETCH: if (cfg_ack)    state_nxt = ST_SHIFT;
         ST_SHIFT: if (word_done)  state_nxt = (cfg_idx == '0) ? ST_LOAD : ST_FETCH;
         ST_LOAD:  if (lcnt == LD_TC) state_nxt = ST_FIN;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      cfg_req     = 1'b0;
      serial_load = 1'b0;
      unique case (state)
         ST_FETCH: begin busy = 1'b1; cfg_req = 1'b1; end
         ST_SHIFT: busy = 1'b1;
         ST_LOAD:  begin busy = 1'b1; serial_load = 1'b1; end
         ST_FIN:   done = 1'b1;
         default:  ;
      endcase
   end

   // Pad index walks down from the top; the load-phase counter only runs
   // in LOAD and is cleared everywhere else.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cfg_idx <= '0;
         lcnt    <= '0;
      end else begin
         if (state == ST_IDLE && xfer_start)
            cfg_idx <= IDX_TOP;
         else if (state == ST_SHIFT && word_done && cfg_idx != '0)
            cfg_idx <= cfg_idx - IW'(1);
         lcnt <= (state == ST_LOAD) ? lcnt + PW'(1) : '0;
      end
   end

   mprj_cfg_shifter #(
      .CFG_BITS (CFG_BITS),
      .CLK_DIV  (CLK_DIV)
   ) u_shifter (
      .clock        (clock),
      .resetn       (resetn),
      .load         (capture),
      .load_data    (cfg_data),
      .go           (shift_go),
      .word_done    (word_done),
      .serial_clock (serial_clock),
      .serial_data  (serial_data)
   );

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
module tb_mprj_io_cfg_loader;

   localparam int NP  = 4;
   localparam int CB  = 13;
   localparam int CD  = 2;
   localparam int BNP = 38;
   localparam int BCD = 1;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   // small chain under test
   logic          xfer_start = 1'b0, cfg_ack = 1'b0;
   logic [CB-1:0] cfg_data = '0;
   logic          busy, done, cfg_req, sclk, sdata, sload;
   logic [1:0]    cfg_idx;

   // full-size chain, fastest serial clock
   logic          b_start = 1'b0, b_ack = 1'b0;
   logic [CB-1:0] b_data = '0;
   logic          b_busy, b_done, b_req, b_sclk, b_sdata, b_sload;
   logic [5:0]    b_idx;

   int n_chk  = 0;
   int n_fail = 0;

   mprj_io_cfg_loader #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(CD)) u_dut (
      .clock(clock), .resetn(resetn), .xfer_start(xfer_start), .busy(busy),
      .done(done), .cfg_req(cfg_req), .cfg_idx(cfg_idx), .cfg_ack(cfg_ack),
      .cfg_data(cfg_data), .serial_clock(sclk), .serial_data(sdata),
      .serial_load(sload));

   mprj_io_cfg_loader #(.NUM_PADS(BNP), .CFG_BITS(CB), .CLK_DIV(BCD)) u_big (
      .clock(clock), .resetn(resetn), .xfer_start(b_start), .busy(b_busy),
      .done(b_done), .cfg_req(b_req), .cfg_idx(b_idx), .cfg_ack(b_ack),
      .cfg_data(b_data), .serial_clock(b_sclk), .serial_data(b_sdata),
      .serial_load(b_sload));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_latency(input int np, input int cd, input int wt);
      return np * (1 + 2 * cd * CB + wt) + cd + 1;
   endfunction

   // ---------------- small chain model + scoreboard ----------------
   bit            exp_bits[$];
   logic [NP*CB-1:0] chain = '0;
   logic [CB-1:0] pad_q [NP];
   int            load_pulses = 0, load_cyc = 0, viol = 0, done_cnt = 0, rise_cnt = 0;
   logic          prev_sdata = 1'b0;

   task automatic push_word(input logic [CB-1:0] w);
      for (int i = CB - 1; i >= 0; i--) exp_bits.push_back(w[i]);
   endtask

   always @(posedge sclk) begin
      rise_cnt++;
      chain = {chain[NP*CB-2:0], sdata};
      if (exp_bits.size() == 0) chk("unexpected_bit", 1, 0);
      else chk("serial_bit", sdata, exp_bits.pop_front());
   end

   always @(posedge sload) begin
      load_pulses++;
      for (int p = 0; p < NP; p++) pad_q[p] = chain[p*CB +: CB];
   end

   always @(negedge clock) begin
      if (sload) load_cyc++;
      if (done) done_cnt++;
      if (sclk === 1'b1 && sdata !== prev_sdata) viol++;
      prev_sdata = sdata;
   end

   // ---------------- big chain model + scoreboard ----------------
   bit            b_exp[$];
   logic [BNP*CB-1:0] b_chain = '0;
   logic [CB-1:0] b_pad [BNP];
   int            b_loads = 0, b_load_cyc = 0, b_viol = 0, b_rise = 0;
   logic          b_prev = 1'b0;

   always @(posedge b_sclk) begin
      b_rise++;
      b_chain = {b_chain[BNP*CB-2:0], b_sdata};
      if (b_exp.size() == 0) chk("big_unexpected_bit", 1, 0);
      else chk("big_serial_bit", b_sdata, b_exp.pop_front());
   end

   always @(posedge b_sload) begin
      b_loads++;
      for (int p = 0; p < BNP; p++) b_pad[p] = b_chain[p*CB +: CB];
   end

   always @(negedge clock) begin
      if (b_sload) b_load_cyc++;
      if (b_sclk === 1'b1 && b_sdata !== b_prev) b_viol++;
      b_prev = b_sdata;
   end

   // ---------------- source model for the small chain ----------------
   task automatic source(input int wait_cyc, input bit spur);
      for (int k = NP - 1; k >= 0; k--) begin
         int t = 0;
         while (cfg_req !== 1'b1 && t < 4000) begin @(negedge clock); t++; end
         if (t >= 4000) begin chk("req_timeout", 0, 1); return; end
         chk("cfg_idx_order", cfg_idx, k);
         for (int w = 0; w < wait_cyc; w++) begin
            @(negedge clock);
            chk("req_held", cfg_req, 1);
            chk("idx_stable", cfg_idx, k);
         end
         cfg_ack  = 1'b1;
         cfg_data = CB'(32'h1800 | k);
         push_word(cfg_data);
         @(negedge clock);
         cfg_ack  = 1'b0;
         cfg_data = '0;
         chk("req_drop", cfg_req, 0);
         if (spur) begin
            // ack with garbage while shifting must not be captured
            cfg_ack  = 1'b1;
            cfg_data = '1;
            repeat (3) @(negedge clock);
            cfg_ack  = 1'b0;
            cfg_data = '0;
         end
      end
   endtask

   task automatic run_transfer(input int wait_cyc, input bit spur, input bit busy_start,
                               input int exp_lat);
      int lat;
      load_pulses = 0; load_cyc = 0; viol = 0; done_cnt = 0; rise_cnt = 0;
      exp_bits.delete();
      @(negedge clock); xfer_start = 1'b1;
      @(negedge clock); xfer_start = 1'b0;
      lat = 1;
      chk("start_busy", busy, 1);
      chk("start_req", cfg_req, 1);
      chk("start_idx", cfg_idx, NP - 1);
      fork
         source(wait_cyc, spur);
         begin
            if (busy_start) xfer_start = 1'b1;   // lands in FETCH
            while (done !== 1'b1 && lat < 6000) begin
               @(negedge clock);
               lat++;
               xfer_start = 1'b0;
               if (busy_start && lat == 20) xfer_start = 1'b1;   // lands in SHIFT
            end
            chk("done_latency", lat, exp_lat);
            if (busy_start) begin
               xfer_start = 1'b1;                 // lands in the done cycle
               @(negedge clock);
               xfer_start = 1'b0;
               chk("busy_after_done", busy, 0);
               chk("req_after_done", cfg_req, 0);
            end
         end
      join
      repeat (300) @(negedge clock);
      chk("done_count", done_cnt, 1);
      chk("load_pulses", load_pulses, 1);
      chk("load_width", load_cyc, CD);
      chk("data_stable_high", viol, 0);
      chk("rise_count", rise_cnt, NP * CB);
      chk("bits_left", exp_bits.size(), 0);
      chk("idle_busy", busy, 0);
      for (int p = 0; p < NP; p++) chk($sformatf("pad%0d_cfg", p), pad_q[p], 32'h1800 | p);
   endtask

   typedef struct {
      int wait_cyc;
      bit spur;
      bit busy_start;
      int exp_lat;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      vecs[0] = '{0, 1'b0, 1'b0, exp_latency(NP, CD, 0)};
      vecs[1] = '{5, 1'b0, 1'b0, exp_latency(NP, CD, 5)};
      vecs[2] = '{0, 1'b1, 1'b1, exp_latency(NP, CD, 0)};
      vecs[3] = '{2, 1'b1, 1'b0, exp_latency(NP, CD, 2)};

      // reset values
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
      chk("rst_req", cfg_req, 0);  chk("rst_idx", cfg_idx, 0);
      chk("rst_sclk", sclk, 0);    chk("rst_sdata", sdata, 0);
      chk("rst_sload", sload, 0);
      resetn = 1'b1;

      // reset mid-SHIFT
      @(negedge clock); xfer_start = 1'b1;
      @(negedge clock); xfer_start = 1'b0;
      load_pulses = 0;
      cfg_ack = 1'b1; cfg_data = 13'h1fff; push_word(13'h1fff);
      @(negedge clock); cfg_ack = 1'b0; cfg_data = '0;
      repeat (30) @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);   chk("mid_rst_done", done, 0);
      chk("mid_rst_req", cfg_req, 0); chk("mid_rst_idx", cfg_idx, 0);
      chk("mid_rst_sclk", sclk, 0);   chk("mid_rst_sdata", sdata, 0);
      chk("mid_rst_sload", sload, 0);
      repeat (3) @(negedge clock);
      chk("mid_rst_no_load", load_pulses, 0);
      exp_bits.delete();
      resetn = 1'b1;

      // spurious ack in IDLE
      @(negedge clock); cfg_ack = 1'b1; cfg_data = '1;
      repeat (5) @(negedge clock);
      chk("spur_idle_busy", busy, 0);
      chk("spur_idle_req", cfg_req, 0);
      chk("spur_idle_sdata", sdata, 0);
      cfg_ack = 1'b0; cfg_data = '0;

      for (int v = 0; v < 4; v++)
         run_transfer(vecs[v].wait_cyc, vecs[v].spur, vecs[v].busy_start, vecs[v].exp_lat);

      // full-size chain, CLK_DIV=1, zero-wait source
      b_exp.delete(); b_rise = 0; b_loads = 0; b_load_cyc = 0; b_viol = 0;
      @(negedge clock); b_start = 1'b1;
      @(negedge clock); b_start = 1'b0;
      lat = 1;
      while (b_done !== 1'b1 && lat < 5000) begin
         b_ack  = b_req;
         b_data = b_idx[0] ? 13'h0AAA : 13'h1555;
         if (b_req) for (int i = CB - 1; i >= 0; i--) b_exp.push_back(b_data[i]);
         @(negedge clock);
         lat++;
      end
      b_ack = 1'b0; b_data = '0;
      chk("big_latency", lat, exp_latency(BNP, BCD, 0));
      repeat (5) @(negedge clock);
      chk("big_rises", b_rise, BNP * CB);
      chk("big_data_stable_high", b_viol, 0);
      chk("big_bits_left", b_exp.size(), 0);
      chk("big_load_pulses", b_loads, 1);
      chk("big_load_width", b_load_cyc, BCD);
      for (int p = 0; p < BNP; p++)
         chk($sformatf("big_pad%0d_cfg", p), b_pad[p], (p % 2) ? 32'h0AAA : 32'h1555);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
